// File: rtl/mul_seq.sv
// Iterative unsigned shift-add multiplier for the MUL/MULTU ALU path.
// A 3-state controller (IDLE -> ADD -> DONE) loads the operands, runs
// exactly WIDTH add/shift steps, and then publishes the 2*WIDTH-bit product.
// The latency is fixed: there is no early exit when the multiplier runs out
// of set bits.
module mul_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADD  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t                r_state;
    logic [2*WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]      r_mplier;
    logic [2*WIDTH-1:0]    r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic [2*WIDTH-1:0]    r_product;
    logic [2*WIDTH-1:0]    w_acc_next;

    // Accumulator value after this step's conditional add; it is also what
    // lands in the product register on the last step.
    always_comb begin
        w_acc_next = r_acc;
        if (r_mplier[0]) begin
            w_acc_next = r_acc + r_mcand;
        end
    end

    // Controller and datapath; busy/done are registered with the state so
    // they never depend combinationally on start.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_product <= w_acc_next;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule
